// File: rtl/axis_dest_demux_if.sv
// AXI-Stream bundle for axis_dest_demux: N lanes of tdata/tkeep/tid/
// tdest/tuser with per-lane tvalid/tready/tlast.
//
// Ports (signals):
//   tdata  [N*DATA_WIDTH]  payload
//   tkeep  [N*KEEP_WIDTH]  byte qualifiers
//   tvalid [N]             beat valid
//   tready [N]             beat ready (driven by the consumer)
//   tlast  [N]             end of frame
//   tid    [N*ID_WIDTH]    stream id
//   tdest  [N*DEST_WIDTH]  routing field
//   tuser  [N*USER_WIDTH]  sideband
// master: producer side, slave: consumer side.

interface axis_dest_demux_if #(
   parameter int N          = 1,
   parameter int DATA_WIDTH = 8,
   parameter int KEEP_WIDTH = 1,
   parameter int ID_WIDTH   = 8,
   parameter int DEST_WIDTH = 8,
   parameter int USER_WIDTH = 1
);

   logic [N*DATA_WIDTH-1:0] tdata;
   logic [N*KEEP_WIDTH-1:0] tkeep;
   logic [N-1:0]            tvalid;
   logic [N-1:0]            tready;
   logic [N-1:0]            tlast;
   logic [N*ID_WIDTH-1:0]   tid;
   logic [N*DEST_WIDTH-1:0] tdest;
   logic [N*USER_WIDTH-1:0] tuser;

   modport master (
      output tdata,
      output tkeep,
      output tvalid,
      input  tready,
      output tlast,
      output tid,
      output tdest,
      output tuser
   );

   modport slave (
      input  tdata,
      input  tkeep,
      input  tvalid,
      output tready,
      input  tlast,
      input  tid,
      input  tdest,
      input  tuser
   );

endinterface

// File: rtl/axis_dest_demux.sv
// AXI-Stream frame demultiplexer: routes each whole frame on s_axis to
// one of M_COUNT outputs chosen by tdest of its first beat.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   s_axis (slave)     single input stream, registered tready
//   m_axis (master)    M_COUNT outputs; payload shared and replicated,
//                      tvalid one-hot (or zero)
//   status_drop_count  dropped frames, saturating at 16'hFFFF

module axis_dest_demux #(
   parameter int M_COUNT        = 4,
   parameter int DATA_WIDTH     = 8,
   parameter bit KEEP_ENABLE    = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH     = (DATA_WIDTH / 8),
   parameter bit ID_ENABLE      = 1,
   parameter int ID_WIDTH       = 8,
   parameter int DEST_WIDTH     = 8,
   parameter bit USER_ENABLE    = 1,
   parameter int USER_WIDTH     = 1,
   parameter bit DROP_UNMATCHED = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   axis_dest_demux_if.slave         s_axis,
   axis_dest_demux_if.master        m_axis,
   output logic [15:0]              status_drop_count
);

   localparam int SW = $clog2(M_COUNT);

   localparam logic [DEST_WIDTH:0] M_LIM =
      (DEST_WIDTH + 1)'(M_COUNT);

   localparam logic [SW-1:0] LAST_SEL = SW'(M_COUNT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ROUTE,
      DROP
   } state_t;

   // One beat as held in the output or skid register. Each register
   // keeps its own select so a new frame cannot retarget a parked beat.
   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [KEEP_WIDTH-1:0] keep;
      logic                  last;
      logic [ID_WIDTH-1:0]   id;
      logic [DEST_WIDTH-1:0] dest;
      logic [USER_WIDTH-1:0] user;
      logic [SW-1:0]         sel;
   } beat_t;

   state_t        state_q, state_d;
   logic [SW-1:0] sel_q, sel_d;
   logic [15:0]   drop_cnt_q, drop_cnt_d;
   logic          s_ready_q, s_ready_d;

   beat_t out_q, out_d;
   beat_t tmp_q, tmp_d;
   logic  out_vld_q, out_vld_d;
   logic  tmp_vld_q, tmp_vld_d;

   beat_t         in_beat;
   logic [SW-1:0] in_sel;
   logic          s_acc;
   logic          dest_hit;
   logic          fwd;
   logic          in_vld;
   logic          m_rdy_cur;

   assign s_acc    = s_axis.tvalid && s_ready_q;
   assign dest_hit = {1'b0, s_axis.tdest} < M_LIM;
   assign in_vld   = s_acc && fwd;

   // Frame control: routing decision is taken on the first beat only.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      drop_cnt_d = drop_cnt_q;
      fwd        = 1'b0;
      in_sel     = sel_q;
      unique case (state_q)
         IDLE: begin
            fwd    = dest_hit || !DROP_UNMATCHED;
            in_sel = dest_hit ? s_axis.tdest[SW-1:0]
                              : LAST_SEL;
            if (s_acc) begin
               if (fwd) begin
                  sel_d = in_sel;
               end else if (drop_cnt_q != 16'hFFFF) begin
                  drop_cnt_d = drop_cnt_q + 16'd1;
               end
               if (!s_axis.tlast) begin
                  state_d = fwd ? ROUTE : DROP;
               end
            end
         end
         ROUTE: begin
            fwd = 1'b1;
            if (s_acc && s_axis.tlast) begin
               state_d = IDLE;
            end
         end
         DROP: begin
            if (s_acc && s_axis.tlast) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Disabled sideband is forced here so the registers carry the
   // final output value.
   always_comb begin
      in_beat.data = s_axis.tdata;
      in_beat.keep = KEEP_ENABLE ? s_axis.tkeep : '1;
      in_beat.last = s_axis.tlast;
      in_beat.id   = ID_ENABLE ? s_axis.tid : '0;
      in_beat.dest = s_axis.tdest;
      in_beat.user = USER_ENABLE ? s_axis.tuser : '0;
      in_beat.sel  = in_sel;
   end

   assign m_rdy_cur = m_axis.tready[out_q.sel];

   // Output register plus one-entry skid. tready is registered, so a
   // beat taken while the output stalls parks in the skid register.
   always_comb begin
      out_d     = out_q;
      tmp_d     = tmp_q;
      out_vld_d = out_vld_q;
      tmp_vld_d = tmp_vld_q;
      s_ready_d = m_rdy_cur ||
                  (!tmp_vld_q && (!out_vld_q || !in_vld));
      if (s_ready_q) begin
         if (m_rdy_cur || !out_vld_q) begin
            out_vld_d = in_vld;
            out_d     = in_beat;
         end else begin
            tmp_vld_d = in_vld;
            tmp_d     = in_beat;
         end
      end else if (m_rdy_cur) begin
         out_vld_d = tmp_vld_q;
         out_d     = tmp_q;
         tmp_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         drop_cnt_q <= '0;
         s_ready_q  <= 1'b0;
         out_vld_q  <= 1'b0;
         tmp_vld_q  <= 1'b0;
         out_q      <= '0;
         tmp_q      <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         drop_cnt_q <= drop_cnt_d;
         s_ready_q  <= s_ready_d;
         out_vld_q  <= out_vld_d;
         tmp_vld_q  <= tmp_vld_d;
         out_q      <= out_d;
         tmp_q      <= tmp_d;
      end
   end

   always_comb begin
      m_axis.tvalid = '0;
      if (out_vld_q) begin
         m_axis.tvalid[out_q.sel] = 1'b1;
      end
   end

   assign m_axis.tdata = {M_COUNT{out_q.data}};
   assign m_axis.tkeep = {M_COUNT{out_q.keep}};
   assign m_axis.tlast = {M_COUNT{out_q.last}};
   assign m_axis.tid   = {M_COUNT{out_q.id}};
   assign m_axis.tdest = {M_COUNT{out_q.dest}};
   assign m_axis.tuser = {M_COUNT{out_q.user}};

   assign s_axis.tready     = s_ready_q;
   assign status_drop_count = drop_cnt_q;

endmodule
